// File: rtl/prog_mem_read_responder_pkg.sv
// prog_mem_read_responder_pkg: channel state encodings and index-width helper shared by the responder.
package prog_mem_read_responder_pkg;
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      READ_WAITING = 2'b01,
      RELAYING     = 2'b10
   } ch_state_e;
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/prog_mem_read_responder_rr.sv
// rr_grant_select: combinational round-robin pick of the first requester at or after ptr_i.
module rr_grant_select #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          gnt_valid_o,
   output logic [IW-1:0] gnt_idx_o
);
   always_comb begin
      int j;
      j = 0;
      gnt_valid_o = 1'b0;
      gnt_idx_o = '0;
      // scan backwards so the requester closest to ptr_i is the last one written
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         j = (j >= N) ? j - N : j;
         if (req_i[j]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o = IW'(j);
         end
      end
   end
endmodule

// File: rtl/prog_mem_read_responder.sv
// prog_mem_read_responder: round-robin arbitration of fetcher reads onto external program-memory channels.
module prog_mem_read_responder
   import prog_mem_read_responder_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);
   localparam int IW = idx_bits(NUM_CONSUMERS);

   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] c_addr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_data;
   ch_state_e                               state_q [NUM_CHANNELS];
   logic [IW-1:0]                           owner_q [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]                busy_q, ready_q;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;
   logic [NUM_CHANNELS-1:0]                 mvalid_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  maddr_q;
   logic [IW-1:0]                           rr_ptr_q, rr_ptr_d;
   logic [NUM_CHANNELS-1:0]                 gnt_v;
   logic [IW-1:0]                           gnt_idx [NUM_CHANNELS];

   assign c_addr = consumer_read_address;
   assign m_data = mem_read_data;
   assign consumer_read_ready = ready_q;
   assign consumer_read_data = data_q;
   assign mem_read_valid = mvalid_q;
   assign mem_read_address = maddr_q;

   // each channel sees the eligible mask minus whatever lower channels already took
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [NUM_CONSUMERS-1:0] req, sel_req;
      logic [IW-1:0]            ptr_in, ptr_out, gi;
      logic                     gv;
      if (c == 0) begin : g_head
         assign req = consumer_read_valid & ~busy_q;
         assign ptr_in = rr_ptr_q;
      end else begin : g_tail
         assign req = g_ch[c-1].gv ? g_ch[c-1].req & ~(NUM_CONSUMERS'(1) << g_ch[c-1].gi) : g_ch[c-1].req;
         assign ptr_in = g_ch[c-1].ptr_out;
      end
      assign sel_req = (state_q[c] == IDLE) ? req : '0;
      rr_grant_select #(.N(NUM_CONSUMERS), .IW(IW)) u_sel (
         .req_i       (sel_req),
         .ptr_i       (rr_ptr_q),
         .gnt_valid_o (gv),
         .gnt_idx_o   (gi)
      );
      assign ptr_out = gv ? ((gi == IW'(NUM_CONSUMERS - 1)) ? '0 : gi + IW'(1)) : ptr_in;
      assign gnt_v[c] = gv;
      assign gnt_idx[c] = gi;
   end

   assign rr_ptr_d = g_ch[NUM_CHANNELS-1].ptr_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= '{default: IDLE};
         owner_q  <= '{default: '0};
         busy_q   <= '0;
         ready_q  <= '0;
         data_q   <= '0;
         mvalid_q <= '0;
         maddr_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (state_q[i])
               IDLE: if (gnt_v[i]) begin
                  owner_q[i]          <= gnt_idx[i];
                  mvalid_q[i]         <= 1'b1;
                  maddr_q[i]          <= c_addr[gnt_idx[i]];
                  busy_q[gnt_idx[i]]  <= 1'b1;
                  state_q[i]          <= READ_WAITING;
               end
               READ_WAITING: if (mem_read_ready[i]) begin
                  mvalid_q[i]         <= 1'b0;
                  data_q[owner_q[i]]  <= m_data[i];
                  ready_q[owner_q[i]] <= 1'b1;
                  state_q[i]          <= RELAYING;
               end
               RELAYING: if (!consumer_read_valid[owner_q[i]]) begin
                  ready_q[owner_q[i]] <= 1'b0;
                  busy_q[owner_q[i]]  <= 1'b0;
                  state_q[i]          <= IDLE;
               end
               default: state_q[i] <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_prog_mem_read_responder.sv
// tb_prog_mem_read_responder: scoreboard bench driving a 1-channel and a 2-channel responder.
module tb_prog_mem_read_responder;
   typedef struct {int c; logic [15:0] d;} exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0]       cv [2];
   logic [3:0][7:0]  ca [2];
   logic [3:0]       cr [2];
   logic [3:0][15:0] cd [2];
   logic [2:0]       mv;
   logic [2:0][7:0]  ma;
   logic [2:0]       mr = '0;
   logic [2:0][15:0] md = '0;
   int cnt [3];
   int stall = 0;
   logic junk = 1'b0;
   logic auto_rel = 1'b1;
   exp_t sbq [2][$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prog_mem_read_responder #(.NUM_CHANNELS(1)) dut1 (
      .clk(clk), .reset(reset),
      .consumer_read_valid(cv[0]), .consumer_read_address(ca[0]),
      .consumer_read_ready(cr[0]), .consumer_read_data(cd[0]),
      .mem_read_valid(mv[0:0]), .mem_read_address(ma[0]),
      .mem_read_ready(mr[0:0]), .mem_read_data(md[0])
   );

   prog_mem_read_responder #(.NUM_CHANNELS(2)) dut2 (
      .clk(clk), .reset(reset),
      .consumer_read_valid(cv[1]), .consumer_read_address(ca[1]),
      .consumer_read_ready(cr[1]), .consumer_read_data(cd[1]),
      .mem_read_valid(mv[2:1]), .mem_read_address(ma[2:1]),
      .mem_read_ready(mr[2:1]), .mem_read_data(md[2:1])
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // memory: word = 0x122F + address, ready after `stall` waiting cycles
   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (mv[c]) begin
            mr[c] = (cnt[c] >= stall);
            md[c] = 16'h122F + 16'(ma[c]);
            cnt[c]++;
         end else begin
            mr[c] = junk;
            cnt[c] = 0;
         end
      end
   end

   // fetchers drop valid once they see ready
   always @(negedge clk) begin
      if (auto_rel)
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
               if (cr[d][i] && cv[d][i]) cv[d][i] = 1'b0;
   end

   // monitor: every rising consumer ready pops the scoreboard
   logic [3:0] prev [2] = '{default: '0};
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            if (cr[d][i] && !prev[d][i]) begin
               if (sbq[d].size() == 0) chk("unexpected_resp", 64'(i), 64'hFFFF);
               else begin
                  e = sbq[d].pop_front();
                  chk($sformatf("resp_dut%0d", d), {32'(i), 16'h0, cd[d][i]}, {32'(e.c), 16'h0, e.d});
               end
            end
         end
         prev[d] = cr[d];
      end
   end

   task automatic issue(input int d, input int i, input logic [7:0] a, input logic [15:0] data);
      cv[d][i] = 1'b1;
      ca[d][i] = a;
      sbq[d].push_back('{i, data});
   endtask

   task automatic wait_ready(input int d, input int i);
      int n = 0;
      while (!cr[d][i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", 64'(cr[d][i]), 64'd1);
   endtask

   task automatic wait_idle(input int d);
      logic idle = 1'b0;
      for (int n = 0; n < 300 && !idle; n++) begin
         @(negedge clk);
         idle = (cv[d] == 0) && (cr[d] == 0) && ((d == 0) ? !mv[0] : (mv[2:1] == 0));
      end
      chk($sformatf("idle_dut%0d", d), 64'(idle), 64'd1);
      chk($sformatf("sb_empty_dut%0d", d), 64'(sbq[d].size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cv = '{default: '0};
      ca = '{default: '0};
      repeat (3) @(negedge clk);
      chk("rst_ready", {cr[1], cr[0]}, 0);
      chk("rst_data", {cd[1], cd[0]}, 0);
      chk("rst_mem", {mv, ma}, 0);
      reset = 1'b0;
      // single read, memory answers the next cycle
      @(negedge clk);
      issue(0, 0, 8'h05, 16'h1234);
      @(negedge clk);
      chk("t1_mvalid", {mv[0], ma[0], cr[0]}, {1'b1, 8'h05, 4'h0});
      @(negedge clk);
      chk("t1_ready", {cr[0], cd[0][0]}, {4'b0001, 16'h1234});
      @(negedge clk);
      chk("t1_release", 64'(cr[0]), 0);
      wait_idle(0);
      // round robin from reset, then from rr_ptr = 2
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      issue(0, 0, 8'h10, 16'h123F);
      issue(0, 1, 8'h11, 16'h1240);
      issue(0, 2, 8'h12, 16'h1241);
      issue(0, 3, 8'h13, 16'h1242);
      wait_idle(0);
      @(negedge clk);
      issue(0, 1, 8'h14, 16'h1243);
      wait_idle(0);
      @(negedge clk);
      issue(0, 2, 8'h18, 16'h1247);
      issue(0, 3, 8'h19, 16'h1248);
      issue(0, 0, 8'h1A, 16'h1249);
      issue(0, 1, 8'h1B, 16'h124A);
      wait_idle(0);
      // two channels take consumers 1 and 3 on the same edge
      @(negedge clk);
      issue(1, 1, 8'h20, 16'h124F);
      issue(1, 3, 8'h30, 16'h125F);
      @(negedge clk);
      chk("t3_dual_valid", 64'(mv[2:1]), 64'd3);
      chk("t3_dual_addr", {ma[2], ma[1]}, {8'h30, 8'h20});
      wait_idle(1);
      // memory stall: request held, no other grant
      stall = 10;
      @(negedge clk);
      issue(0, 0, 8'h40, 16'h126F);
      issue(0, 1, 8'h41, 16'h1270);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk("t4_stall_hold", {mv[0], ma[0], cr[0]}, {1'b1, 8'h40, 4'h0});
      end
      wait_idle(0);
      // consumer withdraws while the read is outstanding
      stall = 3;
      @(negedge clk);
      issue(0, 2, 8'h50, 16'h127F);
      @(negedge clk);
      chk("t5_wait", {mv[0], ma[0]}, {1'b1, 8'h50});
      cv[0][2] = 1'b0;
      wait_ready(0, 2);
      @(negedge clk);
      chk("t5_pulse", 64'(cr[0]), 0);
      issue(0, 2, 8'h51, 16'h1280);
      @(negedge clk);
      chk("t5_regrant", {mv[0], ma[0]}, {1'b1, 8'h51});
      wait_idle(0);
      stall = 0;
      // stray memory ready on idle channels is ignored
      junk = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t7_stray_ready", {cr[1], cr[0], mv}, 0);
      end
      junk = 1'b0;
      // reset while relaying, then consumer 0 wins over consumer 3
      auto_rel = 1'b0;
      @(negedge clk);
      issue(0, 2, 8'h60, 16'h128F);
      wait_ready(0, 2);
      @(negedge clk);
      chk("t6_relay_hold", 64'(cr[0]), 64'b0100);
      reset = 1'b1;
      cv[0] = '0;
      @(negedge clk);
      chk("t6_rst_ctl", {cr[0], mv[0], ma[0]}, 0);
      chk("t6_rst_data", cd[0], 0);
      reset = 1'b0;
      auto_rel = 1'b1;
      issue(0, 0, 8'h70, 16'h129F);
      issue(0, 3, 8'h71, 16'h12A0);
      @(negedge clk);
      chk("t6_first_grant", {mv[0], ma[0]}, {1'b1, 8'h70});
      wait_idle(0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
